// File: rtl/iqmap_16qam_if.sv
// Word-in / symbol-out bundle for the 16-QAM transmit mapper.
interface iqmap_16qam_if;
    logic                valid_i;
    logic [127:0]        data_i;
    logic                ready_o;
    logic                valid_o;
    logic signed [10:0]  ar;
    logic signed [10:0]  ai;
    logic                busy;

    modport master (output valid_i, data_i,
                    input  ready_o, valid_o, ar, ai, busy);
    modport slave  (input  valid_i, data_i,
                    output ready_o, valid_o, ar, ai, busy);
endinterface

// File: rtl/iqmap_16qam.sv
// 16-QAM transmit mapper: 128-bit words serialized MSB-first into 32 Gray-coded I/Q symbols.
// Optional debug outputs valid_raw/raw are enabled by defining IQMAP_16QAM_RAW_EN.
module iqmap_16qam (
    input  logic ck,
    input  logic rst,
    input  logic ce,
`ifdef IQMAP_16QAM_RAW_EN
    output logic       valid_raw,
    output logic [3:0] raw,
`endif
    iqmap_16qam_if.slave bus
);
    localparam int unsigned W_WORD = 128;
    localparam int unsigned W_SYM  = 11;
    localparam int unsigned W_CNT  = 5;
    localparam logic [W_CNT-1:0] LAST_SYM = W_CNT'(31);

    localparam logic signed [W_SYM-1:0] LVL_N1024 = 11'h400;
    localparam logic signed [W_SYM-1:0] LVL_N342  = 11'h6AA;
    localparam logic signed [W_SYM-1:0] LVL_P342  = 11'h156;
    localparam logic signed [W_SYM-1:0] LVL_P1023 = 11'h3FF;

    logic [W_WORD-1:0]       sh, sh_nxt;
    logic [W_WORD-1:0]       hold, hold_nxt;
    logic [W_CNT-1:0]        cnt, cnt_nxt;
    logic                    active, active_nxt;
    logic                    hold_full, hold_full_nxt;
    logic                    valid_q, valid_nxt;
    logic signed [W_SYM-1:0] ar_q, ar_nxt;
    logic signed [W_SYM-1:0] ai_q, ai_nxt;
    logic                    busy_q;
    logic                    ready;
    logic                    accept;
    logic                    last;

    // Gray-coded amplitude for one 2-bit axis code
    function automatic logic signed [W_SYM-1:0] level(input logic [1:0] code);
        logic signed [W_SYM-1:0] v;
        case (code)
            2'b00:   v = LVL_N1024;
            2'b01:   v = LVL_N342;
            2'b11:   v = LVL_P342;
            default: v = LVL_P1023;
        endcase
        return v;
    endfunction

    assign ready  = ~hold_full & ~rst;
    assign accept = bus.valid_i & ready & ce;
    assign last   = active & (cnt == LAST_SYM);

    // Next-state: shift/emit while active, route accepted words to sh or hold
    always_comb begin
        sh_nxt        = sh;
        hold_nxt      = hold;
        cnt_nxt       = cnt;
        active_nxt    = active;
        hold_full_nxt = hold_full;
        valid_nxt     = valid_q;
        ar_nxt        = ar_q;
        ai_nxt        = ai_q;
        if (ce) begin
            if (active) begin
                ar_nxt    = level(sh[127:126]);
                ai_nxt    = level(sh[125:124]);
                valid_nxt = 1'b1;
                sh_nxt    = {sh[W_WORD-5:0], 4'h0};
                cnt_nxt   = cnt + W_CNT'(1);
                if (last) begin
                    if (hold_full) begin
                        sh_nxt        = hold;
                        cnt_nxt       = '0;
                        hold_full_nxt = 1'b0;
                    end else if (accept) begin
                        sh_nxt  = bus.data_i;
                        cnt_nxt = '0;
                    end else begin
                        active_nxt = 1'b0;
                    end
                end else if (accept) begin
                    hold_nxt      = bus.data_i;
                    hold_full_nxt = 1'b1;
                end
            end else begin
                valid_nxt = 1'b0;
                if (accept) begin
                    sh_nxt     = bus.data_i;
                    cnt_nxt    = '0;
                    active_nxt = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge ck) begin
        if (rst) begin
            sh        <= '0;
            hold      <= '0;
            cnt       <= '0;
            active    <= 1'b0;
            hold_full <= 1'b0;
            valid_q   <= 1'b0;
            ar_q      <= '0;
            ai_q      <= '0;
            busy_q    <= 1'b0;
        end else begin
            sh        <= sh_nxt;
            hold      <= hold_nxt;
            cnt       <= cnt_nxt;
            active    <= active_nxt;
            hold_full <= hold_full_nxt;
            valid_q   <= valid_nxt;
            ar_q      <= ar_nxt;
            ai_q      <= ai_nxt;
            busy_q    <= active_nxt | hold_full_nxt;
        end
    end

`ifdef IQMAP_16QAM_RAW_EN
    // Debug mirror of the nibble currently presented on ar/ai
    always_ff @(posedge ck) begin
        if (rst) begin
            valid_raw <= 1'b0;
            raw       <= '0;
        end else begin
            valid_raw <= valid_nxt;
            if (ce && active) raw <= sh[127:124];
        end
    end
`endif

    assign bus.ready_o = ready;
    assign bus.valid_o = valid_q;
    assign bus.ar      = ar_q;
    assign bus.ai      = ai_q;
    assign bus.busy    = busy_q;
endmodule
